// File: rtl/wb_ram_pkg.sv
// Shared types and default configuration for the Wishbone RAM responder.
package wb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] WB_RAM_DEF_ADDR_BASE  = 32'h3800_0000;
  localparam int unsigned WB_RAM_DEF_ADDR_WIDTH = 10;
  localparam int unsigned WB_RAM_DEF_DELAYS     = 4;

endpackage

// File: rtl/wb_ram_bram.sv
// Single-port synchronous word RAM with per-byte write enables and 1-cycle read latency.
module wb_ram_bram #(
  parameter int unsigned AW = 10
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      if (i_we == '0) r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic slave over on-chip RAM with fixed wait states and single-cycle ack.
// Optional one-word sequential-read prefetch buffer: define WB_RAM_PREFETCH_EN.
module wb_ram_responder
  import wb_ram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = WB_RAM_DEF_ADDR_BASE,
  parameter int unsigned ADDR_WIDTH = WB_RAM_DEF_ADDR_WIDTH,
  parameter int unsigned DELAYS     = WB_RAM_DEF_DELAYS
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam logic [3:0]            LAST_CNT = 4'(DELAYS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_WORD = ADDR_WIDTH'(1);

  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_dat;

  logic                  w_active, w_hit_range, w_req, w_access;
  logic                  w_pf_hit, w_pf_issue, w_ram_en;
  logic [ADDR_WIDTH-1:0] w_word, w_ram_addr;
  logic [3:0]            w_ram_we;
  logic [31:0]           w_ram_rdata, w_ack_data;
  logic                  w_unused_adr;

  assign w_unused_adr = &{1'b0, wbs_adr_i[1:0]};
  assign w_active     = wbs_stb_i & wbs_cyc_i;
  assign w_hit_range  = (wbs_adr_i[31:ADDR_WIDTH+2] == ADDR_BASE[31:ADDR_WIDTH+2]);
  assign w_req        = w_active & w_hit_range;
  assign w_word       = wbs_adr_i[ADDR_WIDTH+1:2];
  // The RAM is touched only in the final wait cycle, and only if the master is still there.
  assign w_access     = (r_state == WAIT) && (r_cnt == LAST_CNT) && w_active;

`ifdef WB_RAM_PREFETCH_EN
  logic                  r_pf_valid, r_pf_fill, r_pf_hit;
  logic [ADDR_WIDTH-1:0] r_pf_tag, r_pf_next_tag;
  logic [31:0]           r_pf_data;

  assign w_pf_hit   = !wbs_we_i && r_pf_valid && (r_pf_tag == w_word);
  assign w_pf_issue = (r_state == ACK) && !r_we;
  assign w_ack_data = r_pf_hit ? r_pf_data : w_ram_rdata;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pf_valid <= 1'b0;
      r_pf_fill  <= 1'b0;
      r_pf_hit   <= 1'b0;
    end else begin
      r_pf_fill <= w_pf_issue;
      if (w_pf_issue) r_pf_next_tag <= r_adr + ONE_WORD;
      // Tag travels with the fill so a new request latched meanwhile cannot corrupt it.
      if (r_pf_fill) begin
        r_pf_data  <= w_ram_rdata;
        r_pf_tag   <= r_pf_next_tag;
        r_pf_valid <= 1'b1;
      end
      if (w_access && r_we) r_pf_valid <= 1'b0;
      if ((r_state == IDLE) && w_req) r_pf_hit <= w_pf_hit;
    end
  end
`else
  assign w_pf_hit   = 1'b0;
  assign w_pf_issue = 1'b0;
  assign w_ack_data = w_ram_rdata;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next = w_pf_hit ? ACK : WAIT;
      WAIT: begin
        if (!w_active)              w_next = IDLE;
        else if (r_cnt == LAST_CNT) w_next = ACK;
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_req) begin
        r_adr <= w_word;
        r_we  <= wbs_we_i;
        r_sel <= wbs_sel_i;
        r_dat <= wbs_dat_i;
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign w_ram_en   = w_access | w_pf_issue;
  assign w_ram_we   = (w_access && r_we) ? r_sel : '0;
  assign w_ram_addr = w_access ? r_adr : (r_adr + ONE_WORD);

  wb_ram_bram #(
    .AW (ADDR_WIDTH)
  ) u_bram (
    .i_clk   (wb_clk_i),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_dat),
    .o_rdata (w_ram_rdata)
  );

  assign wbs_ack_o = (r_state == ACK);
  assign wbs_dat_o = (wbs_ack_o && !r_we) ? w_ack_data : '0;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Randomized self-checking bench for wb_ram_responder against a behavioural RAM/latency model.
module tb_wb_ram_responder;

  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam int unsigned AW   = 10;
  localparam int unsigned NW   = 1 << AW;
  localparam int unsigned DLY  = 4;
`ifdef WB_RAM_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  wb_ram_responder #(
    .ADDR_BASE  (BASE),
    .ADDR_WIDTH (AW),
    .DELAYS     (DLY)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state: RAM image, which bytes are defined, and the prefetch buffer.
  logic [31:0] mdl   [NW];
  logic [31:0] known [NW];
  bit          pf_valid = 1'b0;
  int unsigned pf_tag   = 0;
  int unsigned seq_next = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Drives one request; cut_at > 0 drops stb/cyc (or pulses reset) in that cycle.
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int unsigned cut_at, input bit cut_rst,
                          input int unsigned hold, output int unsigned lat,
                          output int unsigned n_ack, output int unsigned leak,
                          output logic [31:0] rd);
    bit cut_done;
    lat = 0; n_ack = 0; leak = 0; rd = '0; cut_done = 1'b0;
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
    for (int unsigned n = 1; n <= hold; n++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        n_ack++;
        if (lat == 0) begin
          lat = n;
          rd  = wbs_dat_o;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      end else if (wbs_dat_o != '0) begin
        leak++;
      end
      if (cut_at != 0 && n == cut_at && lat == 0) begin
        cut_done = 1'b1;
        if (cut_rst) wb_rst_i = 1'b1;
        else if ($urandom_range(0, 1) == 0) wbs_stb_i = 1'b0;
        else wbs_cyc_i = 1'b0;
      end
      if (cut_done && cut_rst && n == cut_at + 1) begin
        wb_rst_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      end
      if (lat != 0 && n == lat + 1) break;
    end
    wb_rst_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input int unsigned cut_at, input bit cut_rst,
                     input string tag);
    int unsigned lat, n_ack, leak, el, w, hold;
    logic [31:0] rd;
    bit hit, exp_ack, cut_applied, commit;
    hit = (adr[31:AW+2] == BASE[31:AW+2]);
    w   = int'(adr[AW+1:2]);
    el  = DLY + 1;
    if (PF_EN && !we && pf_valid && pf_tag == w) el = 1;
    exp_ack     = hit && (cut_at == 0 || el <= cut_at);
    cut_applied = hit && cut_at != 0 && !exp_ack;
    hold        = (hit && cut_at == 0) ? 40 : 20;

    wb_cycle(we, adr, sel, dat, cut_at, cut_rst, hold, lat, n_ack, leak, rd);

    check({tag, "_nack"}, n_ack, exp_ack ? 32'd1 : 32'd0);
    check({tag, "_lat"},  lat,   exp_ack ? el : 32'd0);
    check({tag, "_idle_dat"}, leak, 32'd0);
    if (exp_ack) begin
      if (we) check({tag, "_wr_dat"}, rd, 32'd0);
      else    check({tag, "_rd_dat"}, rd & known[w], mdl[w] & known[w]);
    end

    commit = hit && we && (exp_ack || (cut_applied && cut_rst && cut_at == DLY));
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel[b]) begin
          mdl[w][8*b +: 8]   = dat[8*b +: 8];
          known[w][8*b +: 8] = 8'hFF;
        end
      end
      pf_valid = 1'b0;
    end
    if (exp_ack && !we) begin
      pf_valid = 1'b1;
      pf_tag   = (w + 1) % NW;
      seq_next = pf_tag;
    end
    if (cut_applied && cut_rst) pf_valid = 1'b0;
  endtask

  initial begin
    int unsigned kind, w, cut;
    logic [31:0] a;
    for (int unsigned i = 0; i < NW; i++) begin
      known[i] = '0;
      mdl[i]   = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("reset_dat", wbs_dat_o, 32'd0);
    wb_rst_i = 1'b0;

    run(1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, "wr_full");
    run(1'b0, 32'h3800_0010, 4'hF, 32'h0,         0, 1'b0, "rd_full");
    run(1'b1, 32'h3800_0010, 4'b0010, 32'h0000_AB00, 0, 1'b0, "wr_byte");
    run(1'b0, 32'h3800_0010, 4'h0, 32'h0,         0, 1'b0, "rd_byte");
    run(1'b1, 32'h3800_0010, 4'h0, 32'hFFFF_FFFF, 0, 1'b0, "wr_sel0");
    run(1'b0, 32'h3800_0010, 4'hF, 32'h0,         0, 1'b0, "rd_sel0");
    run(1'b1, 32'h3800_0020, 4'hF, 32'h0BAD_F00D, 0, 1'b0, "pre_abort");
    run(1'b1, 32'h3800_0020, 4'hF, 32'h1234_5678, 2, 1'b0, "abort");
    run(1'b0, 32'h3800_0020, 4'hF, 32'h0,         0, 1'b0, "rd_abort");
    run(1'b1, 32'h3800_0020, 4'hF, 32'h1234_5678, DLY, 1'b0, "abort_last");
    run(1'b0, 32'h3000_0000, 4'hF, 32'h0,         0, 1'b0, "oor");
    run(1'b0, 32'h3800_0010, 4'hF, 32'h0,         0, 1'b0, "rd_after_oor");
    run(1'b1, 32'h3800_0030, 4'hF, 32'h55AA_33CC, 0, 1'b0, "pre_rst");
    run(1'b1, 32'h3800_0030, 4'hF, 32'hCAFE_F00D, 2, 1'b1, "rst_wr");
    run(1'b0, 32'h3800_0030, 4'hF, 32'h0,         0, 1'b0, "rd_rst");
    run(1'b1, 32'h3800_0034, 4'hF, 32'h600D_D00D, DLY, 1'b1, "rst_commit");
    run(1'b0, 32'h3800_0034, 4'hF, 32'h0,         0, 1'b0, "rd_commit");
    run(1'b0, 32'h3800_0010, 4'hF, 32'h0,         0, 1'b0, "seq_a");
    run(1'b0, 32'h3800_0014, 4'hF, 32'h0,         0, 1'b0, "seq_b");
    run(1'b1, 32'h3800_0018, 4'hF, 32'hA5A5_0018, 0, 1'b0, "wr_18");
    run(1'b0, 32'h3800_0018, 4'hF, 32'h0,         0, 1'b0, "rd_18");
    run(1'b1, 32'h3800_0000, 4'hF, 32'h0000_0F00, 0, 1'b0, "wr_000");
    run(1'b1, 32'h3800_0FFC, 4'hF, 32'h0000_0FFC, 0, 1'b0, "wr_ffc");
    run(1'b0, 32'h3800_0FFC, 4'hF, 32'h0,         0, 1'b0, "rd_ffc");
    run(1'b0, 32'h3800_0000, 4'hF, 32'h0,         0, 1'b0, "rd_wrap");

    for (int unsigned i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 99);
      if ($urandom_range(0, 2) == 0) w = seq_next;
      else if ($urandom_range(0, 9) == 0) w = NW - 1;
      else w = $urandom_range(0, 15);
      a = BASE | (w << 2) | 32'($urandom_range(0, 3));
      cut = $urandom_range(1, DLY);
      if (kind < 45)
        run(1'b0, a, 4'($urandom_range(0, 15)), $urandom, 0, 1'b0, "rnd_rd");
      else if (kind < 75)
        run(1'b1, a, 4'($urandom_range(0, 15)), $urandom, 0, 1'b0, "rnd_wr");
      else if (kind < 85)
        run(1'($urandom_range(0, 1)), a, 4'hF, $urandom, cut, 1'b0, "rnd_abort");
      else if (kind < 93)
        run(1'($urandom_range(0, 1)), a, 4'hF, $urandom, cut, 1'b1, "rnd_rst");
      else
        run(1'b0, {~BASE[31:28], a[27:0]}, 4'hF, 32'h0, 0, 1'b0, "rnd_oor");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_ram_responder.md
# wb_ram_responder

Wishbone classic slave that serves CPU and DMA traffic after the RAM arbiter. It sits directly on the arbiter's RAM-side bus and owns a word-addressed on-chip RAM. It adds a fixed, parameterised number of wait states and answers with a single-cycle ack. An optional one-word sequential-read prefetch buffer can be compiled in.

## Interface
- Parameters:
- ADDR_BASE, 32'h3800_0000, byte base address of the RAM window; must be aligned to 4·2^ADDR_WIDTH.
- ADDR_WIDTH, 10, word-address bits (RAM depth 2^ADDR_WIDTH words, 4 KB default).
- DELAYS, 4, wait states before the RAM access; legal range 1..15.
- Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous and active-high.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables for writes.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address; bits [1:0] are ignored.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data; valid only while ack is high.

## Operation
- Request: req = stb & cyc & hit_range.
  - hit_range is true when adr[31:ADDR_WIDTH+2] equals ADDR_BASE[31:ADDR_WIDTH+2].
  - Word address is adr[ADDR_WIDTH+1:2].
- Out-of-range requests are ignored: no ack and no state change. Address decode upstream prevents them.
- FSM states:
  - IDLE: on req, latch adr, we, sel and dat, clear cnt, go to WAIT.
  - WAIT: increment cnt each cycle. When cnt == DELAYS-1, issue the RAM access and go to ACK.
  - ACK: drive wbs_ack_o = 1 for one cycle, then go to IDLE.
- RAM access:
  - Write: byte-masked by the latched sel; sel = 0 still acks and changes nothing.
  - Read: returns the full word regardless of sel. RAM read latency is 1 cycle, and the data drives wbs_dat_o in ACK.
- Abort: if stb or cyc falls while in WAIT, return to IDLE with no ack and no RAM write. The write commits only in the last WAIT cycle.
- After ACK the FSM always passes through IDLE for one cycle, so a held stb cannot be double-acked.
- wbs_dat_o is 0 whenever wbs_ack_o is 0, and during write acks.
- RAM contents are not reset. Contents are undefined until written.

## Timing
- Reset values: wbs_ack_o = 0, wbs_dat_o = 0, state = IDLE, cnt = 0, prefetch valid = 0.
- A request first seen in cycle 0 gets ack in cycle DELAYS+1. With DELAYS = 4, ack is in cycle 5.
- Back-to-back requests are served at best every DELAYS+2 cycles.
- Reset asserted in any state returns the FSM to IDLE at the next edge and drops ack.
  - A write not yet committed is discarded.
  - A write committed in the reset cycle is kept.
- cnt is 4 bits wide and never wraps, because DELAYS is at most 15.

## Configuration
- Macro: WB_RAM_PREFETCH_EN.
- With the macro defined:
  - In ACK of a read, the RAM reads word (addr+1) mod 2^ADDR_WIDTH. Data, tag and valid are registered at the end of the following cycle.
  - In IDLE, a read request whose word address matches the tag with valid = 1 goes directly to ACK. That ack lands in cycle 1 and carries the buffered data.
  - Any write that reaches the RAM clears valid.
  - Reset clears valid.
- Without the macro: no buffer, and every access takes DELAYS+1 cycles.

## Structure
- Package wb_ram_pkg holds:
  - the state enum (IDLE, WAIT, ACK);
  - default constants for ADDR_BASE, ADDR_WIDTH and DELAYS.
- Sub-module wb_ram_bram holds the storage:
  - single port, synchronous, 4 byte-write enables, 1-cycle read latency;
  - instantiated once.

## Test plan
- Full write then read: write 0xDEADBEEF with sel = F to 0x3800_0010, then read the same address → each ack in cycle 5, read data 0xDEADBEEF, ack high exactly 1 cycle.
- Byte write: write 0x0000AB00 with sel = 4'b0010 to 0x3800_0010, then read it → 0xDEADABEF.
- Abort: write 0x12345678 to 0x3800_0020 and drop stb in cycle 2 → no ack; a later read returns the prior value.
- Out of range: read 0x3000_0000 with stb held for 20 cycles → ack never asserts; a following in-range read acks in cycle 5.
- Reset mid-operation: pulse wb_rst_i in cycle 2 of a write of 0xCAFEF00D to 0x3800_0030 → ack stays 0, word unchanged.
- Prefetch (WB_RAM_PREFETCH_EN defined):
  - read 0x3800_0010, then 0x3800_0014 → second read acks in cycle 1;
  - write to 0x3800_0018, then read it → normal 5-cycle latency;
  - read 0x3800_0FFC, then 0x3800_0000 → wrap hit, ack in cycle 1.
